// File: rtl/mode_step_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mode_step_sequencer_pkg
// Brief    : Shared types and constants for the mode step sequencer.
// Revision : 1.0 - initial release
// ============================================================================
package mode_step_sequencer_pkg;

    localparam int c_MODE_W_DEF = 3;
    localparam int c_STEP_W_DEF = 5;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam logic [2:0] c_MODE_0 = 3'b000;
    localparam logic [2:0] c_MODE_1 = 3'b001;
    localparam logic [2:0] c_MODE_2 = 3'b010;
    localparam logic [2:0] c_MODE_3 = 3'b011;
    localparam logic [2:0] c_MODE_4 = 3'b100;
    localparam logic [2:0] c_MODE_5 = 3'b101;

    // A maximum of zero flags a mode as invalid.
    localparam int c_MAX_INVALID = 0;
    localparam int c_MAX_MODE_1  = 6;
    localparam int c_MAX_MODE_3  = 11;
    localparam int c_MAX_MODE_4  = 5;
    localparam int c_MAX_MODE_5  = 16;

endpackage
`default_nettype wire

// File: rtl/mode_step_sequencer_mode_max_lut.sv
`default_nettype none
// ============================================================================
// Module   : mode_max_lut
// Brief    : Combinational mode-code to maximum-step lookup.
// Revision : 1.0 - initial release
// ============================================================================
module mode_max_lut
    import mode_step_sequencer_pkg::*;
#(
    parameter int MODE_W = c_MODE_W_DEF,
    parameter int STEP_W = c_STEP_W_DEF
) (
    input  logic [MODE_W-1:0] mode,
    output logic [STEP_W-1:0] max_step
);

    always_comb begin
        max_step = STEP_W'(c_MAX_INVALID);
        case (mode)
            MODE_W'(c_MODE_1): max_step = STEP_W'(c_MAX_MODE_1);
            MODE_W'(c_MODE_3): max_step = STEP_W'(c_MAX_MODE_3);
            MODE_W'(c_MODE_4): max_step = STEP_W'(c_MAX_MODE_4);
            MODE_W'(c_MODE_5): max_step = STEP_W'(c_MAX_MODE_5);
            default:           max_step = STEP_W'(c_MAX_INVALID);
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/mode_step_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : mode_step_sequencer
// Brief    : Per-mode step sequencer with pause, abort and optional restart.
// Revision : 1.0 - initial release
// ============================================================================
module mode_step_sequencer
    import mode_step_sequencer_pkg::*;
#(
    parameter int MODE_W       = c_MODE_W_DEF,
    parameter int STEP_W       = c_STEP_W_DEF,
    parameter bit AUTO_RESTART = 1'b0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [MODE_W-1:0] mode,
    input  logic              tick,
    input  logic              pause,
    input  logic              abort,
    output logic              busy,
    output logic [STEP_W-1:0] step,
    output logic [STEP_W-1:0] max_step,
    output logic              step_strobe,
    output logic              done,
    output logic              err
);

    state_t            r_state;
    logic              r_busy;
    logic [STEP_W-1:0] r_step;
    logic [STEP_W-1:0] r_max;
    logic              r_strobe;
    logic              r_done;
    logic              r_err;
    logic [STEP_W-1:0] w_lut_max;

    mode_max_lut #(
        .MODE_W (MODE_W),
        .STEP_W (STEP_W)
    ) u_lut (
        .mode     (mode),
        .max_step (w_lut_max)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_busy   <= 1'b0;
            r_step   <= '0;
            r_max    <= '0;
            r_strobe <= 1'b0;
            r_done   <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            r_strobe <= 1'b0;
            r_done   <= 1'b0;
            r_err    <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    // Abort outranks start, so a simultaneous start is dropped silently.
                    if (start && !abort) begin
                        if (w_lut_max != '0) begin
                            r_state <= ST_RUN;
                            r_busy  <= 1'b1;
                            r_step  <= '0;
                            r_max   <= w_lut_max;
                        end else begin
                            r_err <= 1'b1;
                        end
                    end
                end
                ST_RUN: begin
                    if (abort) begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                        r_step  <= '0;
                    end else if (tick) begin
                        if (r_step < r_max) begin
                            r_step   <= r_step + 1'b1;
                            r_strobe <= 1'b1;
                            r_state  <= pause ? ST_PAUSE : ST_RUN;
                        end else begin
                            r_state <= ST_DONE;
                            r_done  <= 1'b1;
                        end
                    end else if (pause) begin
                        r_state <= ST_PAUSE;
                    end
                end
                ST_PAUSE: begin
                    if (abort) begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                        r_step  <= '0;
                    end else if (!pause) begin
                        r_state <= ST_RUN;
                    end
                end
                ST_DONE: begin
                    if (abort) begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                        r_step  <= '0;
                    end else if (AUTO_RESTART) begin
                        r_state  <= ST_RUN;
                        r_step   <= '0;
                        r_strobe <= 1'b1;
                    end else begin
                        // Step is left at the maximum for the display datapath.
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign busy        = r_busy;
    assign step        = r_step;
    assign max_step    = r_max;
    assign step_strobe = r_strobe;
    assign done        = r_done;
    assign err         = r_err;

endmodule
`default_nettype wire
